// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed 7-segment scanner with a double-buffered valid/ready load port.
// Optional build macro SEG_LZ_SUPPRESS_EN enables leading-zero suppression on digits 5..1.
module seg_scan_ctrl #(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk50m,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_valid,
  input  logic [23:0] wr_data,
  output logic        wr_ready,
  output logic        frame_done,
  output logic [6:0]  seg,
  output logic [5:0]  dig
);

  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [23:0]   active;
  logic [23:0]   pending;
  buf_state_t    buf_state;
  buf_state_t    buf_state_nxt;
  logic          boundary;
  logic          take;
  logic          commit;
  logic [3:0]    nib;
  logic          lz_blank;
  logic [6:0]    seg_nxt;
  logic [5:0]    dig_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h3f;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5b;
      4'h3:    s = 7'h4f;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6d;
      4'h6:    s = 7'h7d;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7f;
      4'h9:    s = 7'h6f;
      4'ha:    s = 7'h77;
      4'hb:    s = 7'h7c;
      4'hc:    s = 7'h39;
      4'hd:    s = 7'h5e;
      4'he:    s = 7'h79;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // The frame boundary only exists while scanning is enabled.
  assign boundary = en && (cnt == CNT_LAST) && (idx == 3'd5);

  // Slot counter and digit index.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Load buffer FSM: state register.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) buf_state <= BUF_EMPTY;
    else     buf_state <= buf_state_nxt;
  end

  // Load buffer FSM: next state.
  always_comb begin
    buf_state_nxt = buf_state;
    case (buf_state)
      BUF_EMPTY: if (take)     buf_state_nxt = BUF_FULL;
      BUF_FULL:  if (boundary) buf_state_nxt = BUF_EMPTY;
      default:                 buf_state_nxt = BUF_EMPTY;
    endcase
  end

  // Load buffer FSM: outputs. wr_ready is a pure decode of the state flop.
  always_comb begin
    wr_ready = (buf_state == BUF_EMPTY);
    take     = wr_valid && (buf_state == BUF_EMPTY);
    commit   = boundary && (buf_state == BUF_FULL);
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (take)   pending <= wr_data;
      if (commit) active  <= pending;
    end
  end

  always_comb begin
    case (idx)
      3'd0:    nib = active[3:0];
      3'd1:    nib = active[7:4];
      3'd2:    nib = active[11:8];
      3'd3:    nib = active[15:12];
      3'd4:    nib = active[19:16];
      3'd5:    nib = active[23:20];
      default: nib = 4'h0;
    endcase
  end

`ifdef SEG_LZ_SUPPRESS_EN
  // Blank this digit when it and every more significant digit are zero.
  assign lz_blank = (idx != 3'd0) && ((active >> {idx, 2'b00}) == 24'd0);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    seg_nxt = 7'h00;
    dig_nxt = 6'b111111;
    if (en && (cnt >= BLANK_END)) begin
      dig_nxt = ~(6'b000001 << idx);
      seg_nxt = lz_blank ? 7'h00 : seg_decode(nib);
    end
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      seg        <= 7'h00;
      dig        <= 6'b111111;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dig        <= dig_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position reference model predicts every output
// cycle into exp_q, a negedge monitor pops and compares. Honours SEG_LZ_SUPPRESS_EN.
module tb_seg_scan_ctrl;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 6 * SLOT;

  logic        clk50m = 1'b0;
  logic        rst;
  logic        en;
  logic        wr_valid;
  logic [23:0] wr_data;
  logic        wr_ready;
  logic        frame_done;
  logic [6:0]  seg;
  logic [5:0]  dig;

  seg_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
    .clk50m     (clk50m),
    .rst        (rst),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .frame_done (frame_done),
    .seg        (seg),
    .dig        (dig)
  );

  always #10 clk50m = ~clk50m;

  logic [6:0]  dec_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h00};
  logic [14:0] exp_q[$];
  logic [23:0] m_pend_q[$];
  logic [23:0] m_active;
  int          m_pos;
  bit          m_accepted;
  int          checks = 0;
  int          fails  = 0;
  localparam logic [14:0] RESET_VEC = {1'b1, 1'b0, 6'b111111, 7'h00};

  // Expected {dig, seg} from enable, position within the frame, and the committed value.
  function automatic logic [12:0] model_disp(input bit e, input int pos, input logic [23:0] act);
    int d;
    int c;
    logic [3:0] n;
    logic [6:0] s;
    logic [5:0] dsel;
    d = pos / SLOT;
    c = pos % SLOT;
    if (!e || c < BLANK) return {6'b111111, 7'h00};
    n = 4'((act >> (4 * d)) & 24'hf);
    s = dec_tab[n];
`ifdef SEG_LZ_SUPPRESS_EN
    if (d > 0 && (act >> (4 * d)) == 24'd0) s = 7'h00;
`endif
    dsel = 6'b111111;
    dsel[d] = 1'b0;
    return {dsel, s};
  endfunction

  initial begin : model
    logic [12:0] disp;
    bit bnd;
    bit rdy;
    bit rdy_after;
    forever begin
      @(posedge clk50m or posedge rst);
      if (rst) begin
        m_pos = 0;
        m_active = '0;
        m_pend_q.delete();
        m_accepted = 0;
        exp_q.delete();
        exp_q.push_back(RESET_VEC);
      end else begin
        disp = model_disp(en, m_pos, m_active);
        bnd  = en && (m_pos == FRAME - 1);
        rdy  = (m_pend_q.size() == 0);
        if (bnd && !rdy) m_active = m_pend_q.pop_front();
        m_accepted = wr_valid && rdy;
        if (m_accepted) m_pend_q.push_back(wr_data);
        if (en) m_pos = (m_pos + 1) % FRAME;
        rdy_after = (m_pend_q.size() == 0);
        exp_q.push_back({rdy_after, bnd, disp});
      end
    end
  end

  initial begin : monitor
    logic [14:0] e;
    logic [14:0] a;
    forever begin
      @(negedge clk50m);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {wr_ready, frame_done, dig, seg};
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL scan_out t=%0t got rdy=%b fd=%b dig=%b seg=%h, expected rdy=%b fd=%b dig=%b seg=%h",
                   $time, a[14], a[13], a[12:7], a[6:0], e[14], e[13], e[12:7], e[6:0]);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(posedge clk50m);
    #1;
  endtask

  task automatic check_now(input string name, input logic [14:0] e);
    logic [14:0] a;
    a = {wr_ready, frame_done, dig, seg};
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, a, e);
    end
  endtask

  task automatic write_word(input logic [23:0] d);
    bit done;
    done = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      step();
      done = m_accepted;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL write_timeout data=%h got no transfer, expected transfer", d);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    bit hit;
    hit = (m_pos == p);
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      step();
      hit = (m_pos == p);
    end
    checks++;
    if (!hit) begin
      fails++;
      $display("FAIL wait_pos got pos=%0d expected pos=%0d", m_pos, p);
    end
  endtask

  initial begin : driver
    logic [23:0] r;
    rst = 1'b1; en = 1'b1; wr_valid = 1'b0; wr_data = '0;
    #1;
    check_now("reset_state", RESET_VEC);
    step(3);
    rst = 1'b0;
    step(2 * FRAME + 10);

    // Mid-frame load, commit at the boundary.
    wait_pos(15);
    write_word(24'h543210);
    step(2 * FRAME);

    // Held request while full, then a load landing on the boundary cycle itself.
    wait_pos(3);
    write_word(24'h222222);
    wr_valid = 1'b1; wr_data = 24'hfffffe;
    step(30);
    wr_valid = 1'b0;
    wait_pos(FRAME - 1);
    step(2);
    wait_pos(FRAME - 1);
    wr_valid = 1'b1; wr_data = 24'h9abcde;
    step();
    wr_valid = 1'b0;
    step(2 * FRAME);

    // Freeze in the show phase of digit 3 with a value pending.
    wait_pos(2);
    write_word(24'h876543);
    wait_pos(3 * SLOT + 5);
    en = 1'b0;
    step(37);
    en = 1'b1;
    step(2 * FRAME);

    // Reset while a value is pending.
    wait_pos(1);
    write_word(24'h135799);
    step(5);
    rst = 1'b1;
    #1;
    check_now("reset_async", RESET_VEC);
    step(3);
    rst = 1'b0;
    step(2 * FRAME);

    // Leading-zero patterns.
    write_word(24'h000705);
    step(2 * FRAME);
    write_word(24'h000000);
    step(2 * FRAME);

    // Random traffic with enable dropouts.
    for (int i = 0; i < 800; i++) begin
      r = 24'($urandom());
      for (int k = 0; k < 6; k++) if ($urandom_range(0, 2) == 0) r[4*k +: 4] = 4'h0;
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = r;
      en       = ($urandom_range(0, 19) != 0);
      step();
    end
    en = 1'b1; wr_valid = 1'b0;
    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes six 4-bit digit codes onto the board's shared 7-segment bus (seg, dig), one digit per scan slot.
- Each slot starts with a blanking interval to suppress ghosting.
- Upstream counters and timers load new display values through a valid/ready handshake. Loads are double-buffered and take effect only at a frame boundary, so a frame never mixes old and new values.

Parameters:
- SLOT_CYC, 50000, clk50m cycles per digit slot (1 ms at 50 MHz); must be > BLANK_CYC.
- BLANK_CYC, 500, cycles at the start of each slot with all digits off; must be >= 1.

Ports:
- clk50m  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- en  input  1  scan enable; low freezes scanning and blanks the display
- wr_valid  input  1  new display value offered
- wr_data  input  24  six nibbles; [3:0] = digit 0 (rightmost), [23:20] = digit 5
- wr_ready  output  1  high when a new value can be accepted
- frame_done  output  1  one-cycle pulse at each frame boundary
- seg  output  7  segment drive, active-high, bit0 = a … bit6 = g
- dig  output  6  digit select, active-low, bit i = digit i

Behaviour:
- Reset values: seg=7'h00, dig=6'b111111, wr_ready=1, frame_done=0; slot counter=0, idx=0, active and pending buffers=0, pend_flag=0.
- Slot counter cnt runs 0..SLOT_CYC-1 while en=1.
  - At cnt==SLOT_CYC-1: cnt wraps to 0 and idx advances 0→1→…→5→0.
- Per-slot phases:
  - BLANK phase (cnt < BLANK_CYC): dig=6'b111111, seg=0.
  - SHOW phase (cnt >= BLANK_CYC): dig=~(6'b1<<idx), seg=decode(active[idx]).
- seg and dig are registered, so they lag the cnt/idx state by one cycle.
- Decode table:
  - 0..9 → 3f,06,5b,4f,66,6d,7d,07,7f,6f
  - A→77, B→7c, C→39, D→5e, E→79
  - F→00 (blank code)
- Frame boundary is the cycle with cnt==SLOT_CYC-1 and idx==5. frame_done pulses in the following cycle.
- Handshake:
  - Transfer occurs when wr_valid && wr_ready: pending<=wr_data, pend_flag<=1, wr_ready<=0.
  - At a frame boundary with pend_flag=1: active<=pending, pend_flag<=0, wr_ready<=1 in the next cycle.
  - Net effect: at most one value is buffered. A transfer in the boundary cycle itself, with pend_flag=0, is captured into pending and commits at the next boundary.
  - wr_valid while wr_ready=0 is ignored; the source must hold wr_valid.
- en=0:
  - cnt and idx hold; seg=0, dig=6'b111111 from the next cycle.
  - No frame boundary occurs, so a pending value stays pending and wr_ready stays 0.
  - Transfers are still accepted while wr_ready=1.
  - When en returns to 1, scanning resumes from the held cnt/idx.
- Reset mid-operation: pending is discarded and all state returns to reset values immediately.
- No two dig bits are ever low simultaneously. dig is all-ones for at least BLANK_CYC cycles between consecutive digit changes.

Optional Feature:
- Macro: SEG_LZ_SUPPRESS_EN.
- When defined: leading-zero suppression. Digit i (i=5..1) is shown blank (seg=0, dig still asserted) if its nibble and every higher nibble equal 0. Digit 0 is always decoded normally. The test uses the active buffer, so suppression changes only at frame boundaries.
- When undefined: all six digits are decoded exactly per the table.

Test Plan:
1. Reset state (SLOT_CYC=10, BLANK_CYC=2, en=1): assert rst -> seg=00, dig=111111, wr_ready=1 immediately. Release rst -> digit 0 shows 3f from cnt=2 (+1 cycle register lag), and dig cycles 111110→111101→…→011111 every 10 cycles with 2 blank cycles per slot.
2. Handshake: write 24'h543210 mid-frame -> wr_ready drops next cycle. Display stays all-zero until the frame boundary. frame_done pulses, then digits 0..5 show 3f,06,5b,4f,66,6d, and wr_ready returns to 1.
3. Held request and boundary capture: assert wr_valid continuously with 24'hFFFFFE while wr_ready=0 -> no second capture. A write landing exactly in the boundary cycle commits one frame later.
4. Enable freeze: drop en in the SHOW phase of idx=3 for 37 cycles -> dig=111111, seg=0, idx and cnt frozen, pending retained. Re-raise en -> idx=3 resumes at the same cnt.
5. Reset during pending: write a value, assert rst before the boundary -> active stays 0, wr_ready=1, and no commit occurs after release.
6. SEG_LZ_SUPPRESS_EN: write 24'h000705 -> digits 5,4,3 blank, digit 2 shows 07, digit 1 shows 3f, digit 0 shows 6d. Write 24'h000000 -> only digit 0 shows 3f.
